usr_shift_sequencer: RTL and testbench
======================================

Name: usr_shift_sequencer

Overview:
- Controller plus datapath that sequences the team's universal shift register.
- Accepts a parallel word with a shift command (amount, direction, fill bit) over a valid/ready handshake.
- Loads the word, steps the register one bit per clock for the commanded amount, then presents the result on a valid/ready output.
- Sits between a command-issuing master and any consumer needing variable-distance shifts without a barrel shifter.

Parameters:
- N, 8, data word width in bits.
- AMT_W, 4, width of the shift-amount field; amounts 0..2^AMT_W-1 are legal.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  command/data valid.
- in_ready  output  1  sequencer can accept a command this cycle.
- in_data  input  N  parallel word to load.
- in_amt  input  AMT_W  number of single-bit shift steps.
- in_dir  input  1  1 = shift left (toward MSB), 0 = shift right.
- in_fill  input  1  bit inserted into the vacated end on each step.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  shifted result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: any edge with rst=0 forces IDLE, clears the shift register, the remaining-count register and the latched dir/fill. Reset overrides every other input.
- Values after a reset edge: in_ready=1, out_valid=0, out_data=0, busy=0.
- States: IDLE, SHIFT, DONE. Outputs are decoded from the state: in_ready = IDLE, out_valid = DONE, busy = not IDLE.
- IDLE, accept:
  - Acceptance happens on an edge where in_valid & in_ready.
  - On that edge: register <= in_data, remaining <= in_amt, and dir/fill are latched.
  - Next state is DONE if in_amt == 0, otherwise SHIFT.
- SHIFT, each edge:
  - dir=1: register <= {register[N-2:0], fill}.
  - dir=0: register <= {fill, register[N-1:1]}.
  - remaining decrements; on the edge where remaining == 1 the state moves to DONE.
- Latency: if the accept edge is E0, out_valid is first high after edge E0+in_amt (in_amt=0 gives the cycle immediately after acceptance). Exactly in_amt shift steps are applied.
- Amount > N: no clamping. Each extra step keeps inserting fill, so the result is all fill bits. The counter simply runs to zero.
- DONE:
  - out_data is the register contents, held stable while out_valid=1 and out_ready=0.
  - An edge with out_ready=1 returns to IDLE. out_data keeps its last value (not cleared) until the next load.
- Input during SHIFT/DONE: in_ready=0, so in_valid is ignored and no command is queued. There is no back-to-back accept in the DONE→IDLE cycle; the earliest next accept is the edge after returning to IDLE.
- in_data/in_amt/in_dir/in_fill changes after acceptance have no effect on the operation in flight.
- Reset mid-SHIFT or in DONE: abandons the operation with no out_valid pulse and returns to the reset values above.
- Widths: remaining is AMT_W bits and never underflows, because SHIFT is only entered with a nonzero count.

Decomposition:
- Shared package usr_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Direction constants DIR_RIGHT=0, DIR_LEFT=1.
  - Default N/AMT_W.
- One natural sub-module, usr_datapath:
  - N-bit register with load, shift-enable, direction and fill inputs.
  - Synchronous active-low clear.
- The top level holds the FSM, the remaining-count register and the handshake decode.

Test Plan:
- Reset: hold rst=0 two cycles → in_ready=1, out_valid=0, busy=0, out_data=0x00. Deassert → still idle, no spurious out_valid.
- Left shift: in_data=0x0B, amt=1, dir=1, fill=0, out_ready=1 → out_valid high exactly one cycle after the accept edge, out_data=0x16, then in_ready=1 next cycle.
- Right shift with fill: in_data=0x0B, amt=3, dir=0, fill=1 → out_valid after 3 cycles, out_data=0xE1, busy high across all 3 SHIFT cycles.
- Zero and over-range amounts:
  - amt=0, in_data=0x07 → out_data=0x07 the cycle after accept.
  - in_data=0xFF, amt=10, dir=1, fill=0 → out_data=0x00 after 10 cycles.
- Backpressure: complete amt=2, hold out_ready=0 for 3 cycles while driving in_valid=1 with 0xAA → out_data stable, in_ready=0, 0xAA not accepted. Raise out_ready → IDLE, then 0xAA accepted on the following edge.
- Reset mid-operation: start amt=7, assert rst=0 at the 3rd SHIFT cycle → next cycle out_valid=0, busy=0, out_data=0x00, in_ready=1, and no result is ever presented for the aborted command.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and defaults for the universal shift sequencer.
// The FSM encoding, the direction codes and the default widths live here.
package usr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   localparam int DEF_N     = 8;
   localparam int DEF_AMT_W = 4;

endpackage : usr_pkg

// File: rtl/usr_datapath.sv
// N-bit universal shift register: parallel load, or one-bit shift with fill.
// Load takes priority over shift. A low rst on a clock edge clears the register.
module usr_datapath
   import usr_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_data,
   input  logic         shift_en,
   input  logic         dir,
   input  logic         fill,
   output logic [N-1:0] q
);

   // NOTE: sequential state is written with <= only, so every flop samples
   // values from before the edge and process order cannot change the result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift_en) begin
         if (dir == DIR_LEFT) q <= {q[N-2:0], fill};
         else                 q <= {fill, q[N-1:1]};
      end
   end

endmodule : usr_datapath

// File: rtl/usr_shift_sequencer.sv
// Sequences usr_datapath: accept a word and a shift command, step it one bit
// per clock for the commanded amount, then hold the result until it is taken.
module usr_shift_sequencer
   import usr_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   input  logic             in_fill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [AMT_W-1:0] remaining;
   logic             dir_q;
   logic             fill_q;
   logic             accept;

   assign accept = in_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= '0;
         dir_q     <= DIR_RIGHT;
         fill_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            remaining <= in_amt;
            dir_q     <= in_dir;
            fill_q    <= in_fill;
         end else if (state == SHIFT) begin
            // SHIFT is only entered with a nonzero count, so this cannot wrap.
            remaining <= remaining - AMT_W'(1);
         end
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = (in_amt == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            if (remaining == AMT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   usr_datapath #(.N(N)) u_datapath (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_data (in_data),
      .shift_en  (state == SHIFT),
      .dir       (dir_q),
      .fill      (fill_q),
      .q         (out_data)
   );

endmodule : usr_shift_sequencer

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer; expected values are hand-computed.
module tb_usr_shift_sequencer;

   localparam int N     = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic [AMT_W-1:0] in_amt;
   logic             in_dir;
   logic             in_fill;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_data;
   logic             busy;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   usr_shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .in_fill   (in_fill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'd1);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".busy"},      32'(busy),      32'd0);
   endtask

   task automatic issue(input logic [N-1:0] d, input logic [AMT_W-1:0] a,
                        input logic dr, input logic f);
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      in_fill  = f;
      in_valid = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_dir    = 1'b0;
      in_fill   = 1'b0;
      out_ready = 1'b0;

      // Reset
      step();
      step();
      check_idle("rst");
      check("rst.out_data", 32'(out_data), 32'h00);
      rst = 1'b1;
      step();
      check_idle("post_rst");

      // Left shift 0x0B by 1, fill 0 -> 0x16
      out_ready = 1'b1;
      issue(8'h0B, 4'd1, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      check("l1.shift_busy",  32'(busy),      32'd1);
      check("l1.shift_valid", 32'(out_valid), 32'd0);
      step();
      check("l1.done_valid",  32'(out_valid), 32'd1);
      check("l1.data",        32'(out_data),  32'h16);
      step();
      check_idle("l1.after");

      // Right shift 0x0B by 3, fill 1 -> 0x85, 0xC2, 0xE1
      issue(8'h0B, 4'd3, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("r3.busy%0d", i),  32'(busy),      32'd1);
         check($sformatf("r3.valid%0d", i), 32'(out_valid), 32'd0);
         step();
      end
      check("r3.done_valid", 32'(out_valid), 32'd1);
      check("r3.data",       32'(out_data),  32'hE1);
      step();
      check_idle("r3.after");

      // Zero amount: result on the cycle right after acceptance
      issue(8'h07, 4'd0, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      check("z.valid", 32'(out_valid), 32'd1);
      check("z.data",  32'(out_data),  32'h07);
      step();
      check_idle("z.after");

      // Over-range: 0xFF left by 10, fill 0 -> 0x00 after 10 cycles
      issue(8'hFF, 4'd10, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("o10.valid%0d", i), 32'(out_valid), 32'd0);
         step();
      end
      check("o10.done_valid", 32'(out_valid), 32'd1);
      check("o10.data",       32'(out_data),  32'h00);
      step();
      check_idle("o10.after");

      // Backpressure: 0x81 left by 2 -> 0x04, held while 0xAA is offered
      out_ready = 1'b0;
      issue(8'h81, 4'd2, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      step();
      issue(8'hAA, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp.valid%0d", i),    32'(out_valid), 32'd1);
         check($sformatf("bp.data%0d", i),     32'(out_data),  32'h04);
         check($sformatf("bp.in_ready%0d", i), 32'(in_ready),  32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check_idle("bp.idle");
      check("bp.data_kept", 32'(out_data), 32'h04);
      step();
      in_valid = 1'b0;
      check("bp.aa_busy",     32'(busy),     32'd1);
      check("bp.aa_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp.aa_valid", 32'(out_valid), 32'd1);
      check("bp.aa_data",  32'(out_data),  32'h55);
      step();
      check_idle("bp.after");

      // Reset during the third SHIFT cycle of a 7-step command
      issue(8'hFF, 4'd7, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      step();
      check("mr.busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      step();
      check_idle("mr");
      check("mr.out_data", 32'(out_data), 32'h00);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("mr.no_result%0d", i), 32'(out_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_usr_shift_sequencer
